// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared types, constants and the round-robin pick helper
// for the two-requester arbitrated mux (mux2_rr_arbiter).
//
// Contents:
//   req_id_t  - 1-bit requester identifier
//   REQ0/REQ1 - requester ids
//   LAST_RST  - reset value of the "last granted" register, which gives
//               req0 first priority out of reset
//   rr_pick   - combinational round-robin choice between two requesters
package mux2_arb_pkg;

    typedef logic req_id_t;

    localparam req_id_t REQ0     = 1'b0;
    localparam req_id_t REQ1     = 1'b1;
    localparam req_id_t LAST_RST = REQ1;

    // A lone valid requester wins outright. When both are valid, or neither
    // is, the answer is the requester that was not granted last. With no
    // valid requester the value is only visible on sel and is don't-care.
    function automatic req_id_t rr_pick(
        input logic    v0,
        input logic    v1,
        input req_id_t last
    );
        req_id_t p;
        case ({v0, v1})
            2'b10:   p = REQ0;
            2'b01:   p = REQ1;
            default: p = ~last;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mux2_w.sv
// mux2_w: WIDTH-bit 2:1 multiplexer, the shared datapath of mux2_rr_arbiter.
//
// Ports:
//   a - word selected when c = 0
//   b - word selected when c = 1
//   c - select
//   z - selected word (combinational)
module mux2_w #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] z
);

    // Plain select; no registers in the datapath itself.
    always_comb begin
        if (c) begin
            z = b;
        end else begin
            z = a;
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two valid/ready requesters share one WIDTH-bit 2:1 mux.
// A round-robin arbiter drives the mux select and the chosen word is
// captured in a single-entry output register (1 word/cycle throughput).
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   req0_valid/data      - requester 0 word;  req0_ready: accepted this cycle
//   req1_valid/data      - requester 1 word;  req1_ready: accepted this cycle
//   out_valid/out_data   - registered output word
//   out_ready            - consumer takes the output word
//   sel                  - mux select (0 = req0, 1 = req1), combinational
//   out_src              - registered id of the requester owning out_data
//
// Optional feature (macro MUX2_RR_ARBITER_STATS_EN):
//   grant_cnt0/grant_cnt1 - CNT_W-bit saturating per-requester grant counts
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             out_src
`ifdef MUX2_RR_ARBITER_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    logic             space_s;
    req_id_t          pick_s;
    logic             accept_s;
    logic [WIDTH-1:0] mux_z_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    req_id_t          out_src_r;
    req_id_t          last_r;

    // Arbitration: room in the output register plus round-robin pick.
    // Space counts a word leaving this cycle, so drain and refill overlap.
    always_comb begin
        space_s = !out_valid_r || out_ready;
        pick_s  = rr_pick(req0_valid, req1_valid, last_r);
        if (space_s) begin
            req0_ready = req0_valid && (pick_s == REQ0);
            req1_ready = req1_valid && (pick_s == REQ1);
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    assign sel      = pick_s;
    assign accept_s = req0_ready || req1_ready;

    mux2_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a (req0_data),
        .b (req1_data),
        .c (sel),
        .z (mux_z_s)
    );

    // Output register and round-robin history. An accept wins over a
    // drain, so a simultaneous drain/accept just replaces the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= REQ0;
            last_r      <= LAST_RST;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= mux_z_s;
            out_src_r   <= pick_s;
            last_r      <= pick_s;
        end else if (space_s) begin
            // Either already empty or the consumer took the word.
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;

`ifdef MUX2_RR_ARBITER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    // Saturating grant counters; they stop at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_r <= '0;
            cnt1_r <= '0;
        end else begin
            if (req0_ready && (cnt0_r != {CNT_W{1'b1}})) begin
                cnt0_r <= cnt0_r + CNT_ONE;
            end
            if (req1_ready && (cnt1_r != {CNT_W{1'b1}})) begin
                cnt1_r <= cnt1_r + CNT_ONE;
            end
        end
    end

    assign grant_cnt0 = cnt0_r;
    assign grant_cnt1 = cnt1_r;
`else
    // Counters are absent; CNT_W only needs to be a legal width.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed and random stimulus for mux2_rr_arbiter,
// checked against a behavioural model of the arbitration rules.
module tb_mux2_rr_arbiter;

    localparam int W     = 2;
    localparam int CNT_W = 8;

    logic         clk;
    logic         rst_n;
    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         sel;
    logic         out_src;
`ifdef MUX2_RR_ARBITER_STATS_EN
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;
`endif

    mux2_rr_arbiter #(
        .WIDTH (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sel        (sel),
        .out_src    (out_src)
`ifdef MUX2_RR_ARBITER_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: contents of the output slot and who was granted last.
    int m_valid;
    int m_data;
    int m_src;
    int m_last;
    int m_cnt[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = 0;
        m_data   = 0;
        m_src    = 0;
        m_last   = 1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    // One clock cycle: drive inputs, check grants mid-cycle, then check the
    // registered outputs just after the rising edge.
    task automatic step(input logic v0, input logic [W-1:0] d0,
                        input logic v1, input logic [W-1:0] d1,
                        input logic ordy);
        int win;
        int room;
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        out_ready  = ordy;
        #2;
        room = (m_valid == 0 || ordy) ? 1 : 0;
        win  = -1;
        if (room == 1) begin
            if (v0 && v1)  win = (m_last == 0) ? 1 : 0;
            else if (v0)   win = 0;
            else if (v1)   win = 1;
        end
        chk("req0_ready", {31'd0, req0_ready}, (win == 0) ? 32'd1 : 32'd0);
        chk("req1_ready", {31'd0, req1_ready}, (win == 1) ? 32'd1 : 32'd0);
        if (win >= 0) chk("sel", {31'd0, sel}, win);
        @(posedge clk);
        #1;
        if (win >= 0) begin
            m_valid = 1;
            m_data  = (win == 0) ? int'(d0) : int'(d1);
            m_src   = win;
            m_last  = win;
            if (m_cnt[win] < (1 << CNT_W) - 1) m_cnt[win] = m_cnt[win] + 1;
        end else if (ordy) begin
            m_valid = 0;
        end
        chk("out_valid", {31'd0, out_valid}, m_valid);
        chk("out_data",  {30'd0, out_data},  m_data);
        chk("out_src",   {31'd0, out_src},   m_src);
`ifdef MUX2_RR_ARBITER_STATS_EN
        chk("grant_cnt0", {24'd0, grant_cnt0}, m_cnt[0]);
        chk("grant_cnt1", {24'd0, grant_cnt1}, m_cnt[1]);
`endif
    endtask

    initial begin
        // Reset held with both requesters valid.
        model_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 2'b01;
        req1_valid = 1'b1;
        req1_data  = 2'b10;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {30'd0, out_data},  32'd0);
        chk("rst_out_src",   {31'd0, out_src},   32'd0);
        rst_n = 1'b1;

        // Alternation: first grant to req0, then 01,10,01,10.
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);

        // Backpressure for 3 cycles, then release.
        for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 1'b1, 2'b10, 1'b0);
        step(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);

        // Single requester 1.
        for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b1, 2'b11, 1'b1);

        // Drain to empty after one req0 word.
        step(1'b1, 2'b10, 1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

        // Randomized traffic; a requester keeps its word until accepted.
        begin
            logic         rv0;
            logic         rv1;
            logic [W-1:0] rd0;
            logic [W-1:0] rd1;
            rv0 = 1'b0;
            rv1 = 1'b0;
            rd0 = '0;
            rd1 = '0;
            for (int i = 0; i < 300; i++) begin
                if (!rv0 || req0_ready) begin
                    rv0 = ($urandom_range(0, 2) != 0);
                    rd0 = W'($urandom);
                end
                if (!rv1 || req1_ready) begin
                    rv1 = ($urandom_range(0, 2) != 0);
                    rd1 = W'($urandom);
                end
                step(rv0, rd0, rv1, rd1, ($urandom_range(0, 3) != 0));
            end
        end

        // Long alternating run: 300 grants per requester saturates counters.
        for (int i = 0; i < 600; i++) step(1'b1, W'(i), 1'b1, W'(i + 1), 1'b1);

        // Reset mid-operation discards the pending word at once.
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_data",  {30'd0, out_data},  32'd0);
`ifdef MUX2_RR_ARBITER_STATS_EN
        chk("async_rst_cnt0", {24'd0, grant_cnt0}, 32'd0);
        chk("async_rst_cnt1", {24'd0, grant_cnt1}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // After release req0 has priority again.
        step(1'b1, 2'b11, 1'b1, 2'b01, 1'b1);
        step(1'b1, 2'b11, 1'b1, 2'b01, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
